// File: rtl/io_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : io_intr_ctrl
//  Description : I/O and interrupt controller for the basic computer. Holds
//                INPR/OUTR, the FGI/FGO flags, IEN and R, decodes the
//                register-reference I/O instructions and sequences the
//                RT0-RT2 interrupt cycle strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_intr_ctrl (
    input  logic       CLK,
    input  logic       rst,
    input  logic [6:0] T,
    input  logic       D7,
    input  logic       I,
    input  logic [5:0] B,
    input  logic [7:0] ac_low,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] inpr,
    output logic       fgi,
    output logic       fgo,
    output logic       ien,
    output logic       r_cycle,
    output logic       ld_ac_inpr,
    output logic       skip,
    output logic       clr_ar,
    output logic       ld_tr,
    output logic       str_tr,
    output logic       clr_pc,
    output logic       inr_pc,
    output logic       clr_sc
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } out_state_t;

    out_state_t r_out_state;
    out_state_t w_out_state_nxt;

    logic [7:0] r_inpr;
    logic [7:0] r_outr;
    logic       r_fgi;
    logic       r_fgo;
    logic       r_ien;
    logic       r_r;

    logic       w_p;
    logic       w_inp;
    logic       w_out;
    logic       w_ski;
    logic       w_sko;
    logic       w_ion;
    logic       w_iof;
    logic       w_in_fire;
    logic       w_out_done;
    logic       w_rt0;
    logic       w_rt1;
    logic       w_rt2;
    logic       w_ien_eff;
    logic       w_r_set;
    logic       w_unused_t;

    // Timing slots T4..T6 matter only to the main control unit.
    assign w_unused_t = ^T[6:4];

    // I/O instruction decode, all qualified by D7 & I & T3.
    assign w_p   = D7 & I & T[3];
    assign w_inp = w_p & B[5];
    assign w_out = w_p & B[4];
    assign w_ski = w_p & B[3];
    assign w_sko = w_p & B[2];
    assign w_ion = w_p & B[1];
    assign w_iof = w_p & B[0];

    // Interrupt cycle timing slots.
    assign w_rt0 = r_r & T[0];
    assign w_rt1 = r_r & T[1];
    assign w_rt2 = r_r & T[2];

    // Terminal handshakes.
    assign w_in_fire  = in_valid & ~r_fgi;
    assign w_out_done = (r_out_state == ST_BUSY) & out_ready;

    // An IOF decoded in the same cycle must keep R from being set.
    assign w_ien_eff = r_ien & ~w_iof;
    assign w_r_set   = ~(T[0] | T[1] | T[2]) & w_ien_eff & (r_fgi | r_fgo);

    // Input side: a terminal byte beats a simultaneous INP clearing FGI.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_inpr <= 8'h00;
            r_fgi  <= 1'b0;
        end else if (w_in_fire) begin
            r_inpr <= in_data;
            r_fgi  <= 1'b1;
        end else if (w_inp) begin
            r_fgi  <= 1'b0;
        end
    end

    // Output side: OUT loads OUTR and clears FGO, winning over a completion.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_outr <= 8'h00;
            r_fgo  <= 1'b1;
        end else if (w_out) begin
            r_outr <= ac_low;
            r_fgo  <= 1'b0;
        end else if (w_out_done) begin
            r_fgo  <= 1'b1;
        end
    end

    // Output engine state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_out_state <= ST_IDLE;
        end else begin
            r_out_state <= w_out_state_nxt;
        end
    end

    // Output engine next state: OUT always (re)enters BUSY.
    always_comb begin
        w_out_state_nxt = r_out_state;
        case (r_out_state)
            ST_IDLE: if (w_out) w_out_state_nxt = ST_BUSY;
            ST_BUSY: if (!w_out && out_ready) w_out_state_nxt = ST_IDLE;
            default: w_out_state_nxt = ST_IDLE;
        endcase
    end

    // IEN and R: RT2 ends the interrupt cycle and disables interrupts.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_ien <= 1'b0;
            r_r   <= 1'b0;
        end else begin
            if (w_rt2) begin
                r_ien <= 1'b0;
            end else if (w_ion) begin
                r_ien <= 1'b1;
            end else if (w_iof) begin
                r_ien <= 1'b0;
            end

            if (w_rt2) begin
                r_r <= 1'b0;
            end else if (w_r_set) begin
                r_r <= 1'b1;
            end
        end
    end

    // Combinational strobes and register views.
    assign ld_ac_inpr = w_inp;
    assign skip       = (w_ski & r_fgi) | (w_sko & r_fgo);
    assign clr_ar     = w_rt0;
    assign ld_tr      = w_rt0;
    assign str_tr     = w_rt1;
    assign clr_pc     = w_rt1;
    assign inr_pc     = w_rt2;
    assign clr_sc     = w_p | w_rt2;

    assign in_ready   = ~r_fgi;
    assign out_data   = r_outr;
    assign out_valid  = (r_out_state == ST_BUSY);
    assign inpr       = r_inpr;
    assign fgi        = r_fgi;
    assign fgo        = r_fgo;
    assign ien        = r_ien;
    assign r_cycle    = r_r;

endmodule
`default_nettype wire

// File: tb/tb_io_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_intr_ctrl
//  Description : Table-driven self-checking bench for io_intr_ctrl with a
//                queue of expected post-edge register states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_intr_ctrl;

    // Strobe vector order: {ld_ac_inpr, skip, clr_ar, ld_tr, str_tr, clr_pc, inr_pc, clr_sc, in_ready}
    localparam logic [8:0] S_LD   = 9'h100;
    localparam logic [8:0] S_SKIP = 9'h080;
    localparam logic [8:0] S_CAR  = 9'h040;
    localparam logic [8:0] S_LTR  = 9'h020;
    localparam logic [8:0] S_STR  = 9'h010;
    localparam logic [8:0] S_CPC  = 9'h008;
    localparam logic [8:0] S_IPC  = 9'h004;
    localparam logic [8:0] S_CSC  = 9'h002;
    localparam logic [8:0] S_IRDY = 9'h001;
    // Flag vector order: {fgi, fgo, ien, r_cycle, out_valid}
    localparam logic [4:0] F_FGI  = 5'b10000;
    localparam logic [4:0] F_FGO  = 5'b01000;
    localparam logic [4:0] F_IEN  = 5'b00100;
    localparam logic [4:0] F_R    = 5'b00010;
    localparam logic [4:0] F_OV   = 5'b00001;
    localparam logic [5:0] B_INP  = 6'b100000;
    localparam logic [5:0] B_OUT  = 6'b010000;
    localparam logic [5:0] B_SKI  = 6'b001000;
    localparam logic [5:0] B_SKO  = 6'b000100;
    localparam logic [5:0] B_ION  = 6'b000010;
    localparam logic [5:0] B_IOF  = 6'b000001;
    localparam logic [6:0] T0 = 7'd1, T1 = 7'd2, T2 = 7'd4, T3 = 7'd8, T4 = 7'd16, T5 = 7'd32;

    typedef struct packed {
        logic       rst;
        logic [6:0] t;
        logic       d7;
        logic       i;
        logic [5:0] b;
        logic [7:0] ac;
        logic [7:0] din;
        logic       vin;
        logic       ordy;
        logic       chk_comb;
        logic [8:0] strb;
        logic [7:0] inpr;
        logic [7:0] outr;
        logic [4:0] flags;
    } vec_t;

    typedef struct packed {
        logic [7:0] inpr;
        logic [7:0] outr;
        logic [4:0] flags;
    } state_t;

    logic       CLK = 1'b0;
    logic       rst;
    logic [6:0] T;
    logic       D7, I;
    logic [5:0] B;
    logic [7:0] ac_low, in_data;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [7:0] out_data, inpr;
    logic       fgi, fgo, ien, r_cycle;
    logic       ld_ac_inpr, skip, clr_ar, ld_tr, str_tr, clr_pc, inr_pc, clr_sc;

    int     n_checks = 0;
    int     n_errors = 0;
    state_t exp_q[$];
    vec_t   tbl[$];

    io_intr_ctrl dut (
        .CLK(CLK), .rst(rst), .T(T), .D7(D7), .I(I), .B(B),
        .ac_low(ac_low), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .r_cycle(r_cycle),
        .ld_ac_inpr(ld_ac_inpr), .skip(skip), .clr_ar(clr_ar), .ld_tr(ld_tr),
        .str_tr(str_tr), .clr_pc(clr_pc), .inr_pc(inr_pc), .clr_sc(clr_sc)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Generic (non-I/O) cycle.
    function automatic vec_t gv(input logic r, input logic [6:0] t, input logic [7:0] din,
                                input logic vin, input logic ordy, input logic [8:0] strb,
                                input logic [7:0] ei, input logic [7:0] eo, input logic [4:0] ef);
        vec_t v;
        v = '{rst: r, t: t, d7: 1'b0, i: 1'b0, b: 6'd0, ac: 8'h00, din: din, vin: vin,
              ordy: ordy, chk_comb: 1'b1, strb: strb, inpr: ei, outr: eo, flags: ef};
        return v;
    endfunction

    // I/O instruction at T3 (D7 = I = 1).
    function automatic vec_t io(input logic [5:0] b, input logic [7:0] ac, input logic [7:0] din,
                                input logic vin, input logic ordy, input logic [8:0] strb,
                                input logic [7:0] ei, input logic [7:0] eo, input logic [4:0] ef);
        vec_t v;
        v = gv(1'b0, T3, din, vin, ordy, strb, ei, eo, ef);
        v.d7 = 1'b1;
        v.i  = 1'b1;
        v.b  = b;
        v.ac = ac;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        state_t s;
        state_t a;
        logic [8:0] act_strb;
        @(negedge CLK);
        rst = v.rst; T = v.t; D7 = v.d7; I = v.i; B = v.b; ac_low = v.ac;
        in_data = v.din; in_valid = v.vin; out_ready = v.ordy;
        exp_q.push_back('{inpr: v.inpr, outr: v.outr, flags: v.flags});
        #2;
        if (v.chk_comb) begin
            act_strb = {ld_ac_inpr, skip, clr_ar, ld_tr, str_tr, clr_pc, inr_pc, clr_sc, in_ready};
            n_checks++;
            if (act_strb !== v.strb) begin
                n_errors++;
                $display("FAIL %s strobes: got %b expected %b", name, act_strb, v.strb);
            end
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s state: scoreboard empty", name);
        end else begin
            s = exp_q.pop_front();
            a = '{inpr: inpr, outr: out_data, flags: {fgi, fgo, ien, r_cycle, out_valid}};
            if (a !== s) begin
                n_errors++;
                $display("FAIL %s state: got inpr=%h outr=%h flags=%b expected inpr=%h outr=%h flags=%b",
                         name, a.inpr, a.outr, a.flags, s.inpr, s.outr, s.flags);
            end
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; T = T0; D7 = 1'b0; I = 1'b0; B = '0; ac_low = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // Reset for two cycles (strobes unknown before the first edge).
        v = gv(1, T0, 8'h00, 0, 0, 9'h0, 8'h00, 8'h00, F_FGO); v.chk_comb = 1'b0; tbl.push_back(v);
        tbl.push_back(gv(1, T0, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO));
        // Input handshake, then a second byte ignored while FGI=1.
        tbl.push_back(gv(0, T1, 8'hA5, 1, 0, S_IRDY, 8'hA5, 8'h00, F_FGI | F_FGO));
        tbl.push_back(gv(0, T2, 8'h11, 1, 0, 9'h0,   8'hA5, 8'h00, F_FGI | F_FGO));
        tbl.push_back(io(B_INP, 8'h00, 8'h00, 0, 0, S_LD | S_CSC, 8'hA5, 8'h00, F_FGO));
        // OUT, SKO with FGO=0, completion.
        tbl.push_back(io(B_OUT, 8'h3C, 8'h00, 0, 0, S_CSC | S_IRDY, 8'hA5, 8'h3C, F_OV));
        tbl.push_back(io(B_SKO, 8'h00, 8'h00, 0, 0, S_CSC | S_IRDY, 8'hA5, 8'h3C, F_OV));
        tbl.push_back(gv(0, T0, 8'h00, 0, 1, S_IRDY, 8'hA5, 8'h3C, F_FGO));
        // Skips with flags set.
        tbl.push_back(gv(0, T1, 8'h5A, 1, 0, S_IRDY, 8'h5A, 8'h3C, F_FGI | F_FGO));
        tbl.push_back(io(B_SKI, 8'h00, 8'h00, 0, 0, S_SKIP | S_CSC, 8'h5A, 8'h3C, F_FGI | F_FGO));
        tbl.push_back(io(B_SKO, 8'h00, 8'h00, 0, 0, S_SKIP | S_CSC, 8'h5A, 8'h3C, F_FGI | F_FGO));
        // OUT beats out_ready; OUT while BUSY overwrites OUTR.
        tbl.push_back(io(B_OUT, 8'h77, 8'h00, 0, 1, S_CSC, 8'h5A, 8'h77, F_FGI | F_OV));
        tbl.push_back(io(B_OUT, 8'h88, 8'h00, 0, 1, S_CSC, 8'h5A, 8'h88, F_FGI | F_OV));
        tbl.push_back(gv(0, T0, 8'h00, 0, 1, 9'h0, 8'h5A, 8'h88, F_FGI | F_FGO));
        // INP clears FGI; INP with in_valid and FGI=0: handshake wins.
        tbl.push_back(io(B_INP, 8'h00, 8'h00, 0, 0, S_LD | S_CSC, 8'h5A, 8'h88, F_FGO));
        tbl.push_back(io(B_INP, 8'h00, 8'hC3, 1, 0, S_LD | S_CSC | S_IRDY, 8'hC3, 8'h88, F_FGI | F_FGO));
        tbl.push_back(io(B_INP, 8'h00, 8'h00, 0, 0, S_LD | S_CSC, 8'hC3, 8'h88, F_FGO));
        // ION, then next instruction reaches T3 -> R, then RT0..RT2.
        tbl.push_back(io(B_ION, 8'h00, 8'h00, 0, 0, S_CSC | S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN));
        tbl.push_back(gv(0, T0, 8'h00, 0, 0, S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN));
        tbl.push_back(gv(0, T1, 8'h00, 0, 0, S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN));
        tbl.push_back(gv(0, T2, 8'h00, 0, 0, S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN));
        tbl.push_back(gv(0, T3, 8'h00, 0, 0, S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN | F_R));
        tbl.push_back(gv(0, T0, 8'h00, 0, 0, S_CAR | S_LTR | S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN | F_R));
        tbl.push_back(gv(0, T1, 8'h00, 0, 0, S_STR | S_CPC | S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN | F_R));
        tbl.push_back(gv(0, T2, 8'h00, 0, 0, S_IPC | S_CSC | S_IRDY, 8'hC3, 8'h88, F_FGO));
        tbl.push_back(gv(0, T0, 8'h00, 0, 0, S_IRDY, 8'hC3, 8'h88, F_FGO));
        // IOF at T3 with IEN=1 and flags pending: R suppressed.
        tbl.push_back(io(B_ION, 8'h00, 8'h00, 0, 0, S_CSC | S_IRDY, 8'hC3, 8'h88, F_FGO | F_IEN));
        tbl.push_back(gv(0, T0, 8'h42, 1, 0, S_IRDY, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T1, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T2, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(io(B_IOF, 8'h00, 8'h00, 0, 0, S_CSC, 8'h42, 8'h88, F_FGI | F_FGO));
        tbl.push_back(gv(0, T4, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO));
        // Reset in the middle of an interrupt cycle.
        tbl.push_back(io(B_ION, 8'h00, 8'h00, 0, 0, S_CSC, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T0, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T1, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T2, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN));
        tbl.push_back(gv(0, T5, 8'h00, 0, 0, 9'h0, 8'h42, 8'h88, F_FGI | F_FGO | F_IEN | F_R));
        tbl.push_back(gv(1, T0, 8'h00, 0, 0, S_CAR | S_LTR, 8'h00, 8'h00, F_FGO));
        tbl.push_back(gv(0, T1, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO));

        foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

        // Hand-written: a terminal byte arriving during RT0 sets FGI normally.
        apply(io(B_ION, 8'h00, 8'h00, 0, 0, S_CSC | S_IRDY, 8'h00, 8'h00, F_FGO | F_IEN), "h_ion");
        apply(gv(0, T0, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO | F_IEN), "h_t0");
        apply(gv(0, T1, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO | F_IEN), "h_t1");
        apply(gv(0, T2, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO | F_IEN), "h_t2");
        apply(gv(0, T3, 8'h00, 0, 0, S_IRDY, 8'h00, 8'h00, F_FGO | F_IEN | F_R), "h_rset");
        apply(gv(0, T0, 8'h99, 1, 0, S_CAR | S_LTR | S_IRDY, 8'h99, 8'h00, F_FGI | F_FGO | F_IEN | F_R), "h_rt0");
        apply(gv(0, T1, 8'h00, 0, 0, S_STR | S_CPC, 8'h99, 8'h00, F_FGI | F_FGO | F_IEN | F_R), "h_rt1");
        apply(gv(0, T2, 8'h00, 0, 0, S_IPC | S_CSC, 8'h99, 8'h00, F_FGI | F_FGO), "h_rt2");
        apply(gv(0, T3, 8'h00, 0, 0, 9'h0, 8'h99, 8'h00, F_FGI | F_FGO), "h_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_intr_ctrl.md
# io_intr_ctrl

Input/output and interrupt controller for the basic computer. It owns the INPR/OUTR registers, the FGI/FGO flags, the IEN and R flip-flops, and a two-state output handshake engine. It decodes register-reference I/O instructions (D7·I·T3) from the timing and instruction fields, and sequences the three-cycle interrupt cycle (RT0–RT2) by issuing strobes to the AR/PC/TR/RAM/SC controllers. It sits beside the main control unit, between the external terminal handshakes and the datapath.

## Interface
- No parameters; data widths fixed (INPR/OUTR 8 bits, AC low byte).
- CLK  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- T  in  7  one-hot timing signals T0..T6 from the sequence counter
- D7  in  1  opcode decoder output 7
- I  in  1  indirect/IO bit (IR15) as held in the I flip-flop
- B  in  6  IR[11:6]: B[5]=INP, B[4]=OUT, B[3]=SKI, B[2]=SKO, B[1]=ION, B[0]=IOF
- ac_low  in  8  AC[7:0]
- in_data  in  8  terminal input byte
- in_valid  in  1  terminal has a byte
- in_ready  out  1  controller accepts a byte (= ~fgi)
- out_data  out  8  OUTR contents
- out_valid  out  1  OUTR holds an unsent byte
- out_ready  in  1  terminal accepts byte
- inpr  out  8  INPR register
- fgi, fgo, ien, r_cycle  out  1 each  flag/flip-flop states
- ld_ac_inpr  out  1  AC[7:0] ← INPR this cycle
- skip  out  1  PC increment request (SKI/SKO)
- clr_ar, ld_tr, str_tr, clr_pc, inr_pc, clr_sc  out  1 each  interrupt/IO strobes

## Operation
- p = D7 & I & T[3]; all I/O decodes qualified by p. Any p asserts clr_sc.
- INP (p&B[5]): ld_ac_inpr=1 (pre-edge inpr); fgi←0.
- OUT (p&B[4]): OUTR←ac_low; fgo←0; output engine → BUSY.
- SKI: skip=fgi. SKO: skip=fgo. Combinational, same cycle.
- ION: ien←1. IOF: ien←0.
- Input handshake: in_ready=~fgi. On in_valid&in_ready: inpr←in_data, fgi←1.
- Output engine states IDLE (out_valid=0) / BUSY (out_valid=1). BUSY & out_ready → IDLE, fgo←1. OUT while BUSY: overwrite OUTR, stay BUSY.
- R set: at edge where ~(T0|T1|T2) & ien_eff & (fgi|fgo), ien_eff = ien & ~(p&B[0]) — IOF in the same cycle suppresses R.
- Interrupt cycle (r_cycle=1): T0: clr_ar, ld_tr. T1: str_tr, clr_pc. T2: inr_pc, clr_sc; ien←0, r_cycle←0.
- All strobes are zero when their qualifying term is false; no strobe asserted in more than one cycle per event.

## Timing
- Reset values: inpr=0, OUTR=0, fgi=0, fgo=1, ien=0, r_cycle=0, output engine IDLE; all strobes 0.
- Flag/register updates take effect the cycle after the decode edge; skip, ld_ac_inpr, strobes are combinational from current T/state.
- ION at T3 sets ien at that edge; R set sees old ien, so earliest R is T3 of the following instruction (one instruction executes after ION).
- INP and in_valid in the same cycle with fgi=0: handshake wins (fgi←1, inpr←in_data); ld_ac_inpr uses old inpr.
- OUT and out_ready same cycle: OUT wins (fgo←0, BUSY).
- Terminal handshake completing during RT0–RT2 updates flags normally; R not re-set until T3 or later.
- rst mid-interrupt-cycle: r_cycle, ien cleared next edge; strobes drop immediately once reset state is registered.

## Test plan
- Reset: assert rst 2 cycles → inpr=0x00, fgi=0, fgo=1, ien=0, r_cycle=0, out_valid=0.
- Input: in_data=0xA5, in_valid=1 → next cycle fgi=1, inpr=0xA5, in_ready=0; INP at T3 → ld_ac_inpr=1, fgi=0 next cycle.
- Output: ac_low=0x3C, OUT at T3 → out_data=0x3C, out_valid=1, fgo=0; out_ready=1 → fgo=1, out_valid=0.
- Skips: fgi=1, SKI at T3 → skip=1, clr_sc=1; fgo=0, SKO → skip=0.
- Interrupt: ION, then next instruction reaches T3 with fgo=1 → r_cycle=1; T0: clr_ar,ld_tr; T1: str_tr,clr_pc; T2: inr_pc,clr_sc, then ien=0,r_cycle=0.
- IOF with ien=1, fgi=1 at T3 → r_cycle stays 0, ien=0.
